integral_image_builder: RTL and testbench
=========================================

// Module: integral_image_builder
// PURPOSE
//   Converts a raster stream of 4-bit grayscale pixels (160x120, post-downscale) into an integral
//   image and writes it into the Integral Image RAM consumed by the VGA display stage.
//   Upstream of the display stage: produces exactly the 20-bit, 15-bit-addressed words it reads.
//   ii(r,c) = sum of px(r',c') for r'<=r, c'<=c; address = r*WIDTH + c.
// PARAMETERS
//   WIDTH   160  pixels per row (>=4)
//   HEIGHT  120  rows per frame
//   PX_W    4    pixel width
//   II_W    20   integral word width (15*160*120 = 288000 < 2^20)
//   ADDR_W  15   RAM address width
// PORTS
//   clk         in   1       system clock, single domain
//   rst_n       in   1       asynchronous, active-low reset
//   px_valid    in   1       pixel qualifier; one pixel per cycle max, no backpressure
//   px_sof      in   1       start of frame, valid only with px_valid (marks pixel (0,0))
//   px_data     in   PX_W    grayscale pixel
//   wr_en       out  1       RAM write strobe
//   wr_addr     out  ADDR_W  RAM write address
//   wr_data     out  II_W    integral value
//   frame_done  out  1       1-cycle pulse: last word (HEIGHT*WIDTH-1) written this cycle
//   frame_abort out  1       1-cycle pulse: frame restarted by px_sof before completion
// BEHAVIOUR
//   Reset: all outputs 0; FSM IDLE; counters, row_sum, pipeline cleared. Line buffer need not clear.
//   FSM: IDLE -> ACTIVE on px_valid&px_sof; ACTIVE -> DONE after pixel (HEIGHT-1,WIDTH-1) accepted;
//     DONE -> IDLE after final write issued (frame_done same cycle as that wr_en).
//   IDLE: px_valid without px_sof ignored (no write, no counter change).
//   ACTIVE: each px_valid accepted; col 0..WIDTH-1 wraps, row increments on wrap.
//   px_valid&px_sof in ACTIVE: frame_abort pulses; pixel treated as (0,0) of new frame;
//     in-flight words of old frame still written (max 2).
//   px_valid&px_sof in DONE: accepted as new frame (0,0), no abort.
//   Pipeline (pixel accepted at cycle N):
//     S0 (N): row_sum <= (col==0 ? 0 : row_sum) + px_data; line buffer read at col.
//     S1 (N+1): ii = row_sum + (row==0 ? 0 : lb_rdata); write ii into line buffer at col.
//     Output regs (N+2): wr_en=1, wr_addr=row*WIDTH+col, wr_data=ii.
//   Latency pixel -> wr_en: exactly 2 cycles; throughput 1 word/cycle, gaps preserved.
//   Arithmetic: row_sum zero-extended to II_W; unsigned adds, no saturation (range proven fits).
//   wr_addr computed incrementally (+1 per accepted pixel, 0 at sof), no multiplier.
//   Line buffer read-before-write: S1 write col c never collides with S0 read (col != c for WIDTH>=4).
//   Async reset mid-frame: everything drops immediately; next frame needs px_sof.
// STRUCTURE
//   Shared package/header: II_WIDTH=160, II_HEIGHT=120, II_W=20, II_ADDR_W=15, PX_W=4,
//     shared with the display stage so both agree on geometry.
//   Sub-module ii_line_buffer: WIDTH x II_W single-port sync RAM, 1-cycle read, write-enable;
//     infers block RAM. FSM, counters, adders stay in top.
// TESTING
//   1. Frame of all px=1 -> wr_data at addr r*160+c == (r+1)*(c+1); addr 19199 == 19200; one frame_done.
//   2. All px=15 -> last word 288000 (0x46500), no wrap; single pixel px(0,0)=7, rest 0 -> every word 7.
//   3. px_valid with 3-cycle gaps -> wr_en follows each accepted pixel at +2 cycles, addresses contiguous.
//   4. Pixels before any sof -> no wr_en; sof at pixel 500 of frame -> frame_abort, next write addr 0.
//   5. rst_n low at pixel 8000 -> outputs 0 asynchronously; after release, clean frame matches model.
//   6. Back-to-back frames, sof on cycle after last pixel -> frame_done then addr 0 with no gap/abort.

Source files
------------

// File: rtl/integral_image_builder_pkg.sv
// rtl/integral_image_builder_pkg.sv - shared geometry and types for the integral image path
//
// Purpose: frame geometry and word widths agreed between this builder and the
//          VGA display stage that reads the Integral Image RAM, plus the FSM state type.
// Ports:   none (package).
package integral_image_builder_pkg;

   localparam int II_WIDTH  = 160;  // pixels per row
   localparam int II_HEIGHT = 120;  // rows per frame
   localparam int II_W      = 20;   // integral word width: 15*160*120 = 288000 < 2^20
   localparam int II_ADDR_W = 15;   // RAM address width
   localparam int PX_W      = 4;    // grayscale pixel width

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DONE
   } ii_state_t;

endpackage

// File: rtl/ii_line_buffer.sv
// rtl/ii_line_buffer.sv - one-row store of the previous row's integral values
//
// Purpose: DEPTH x DW synchronous RAM with a 1-cycle read. One read address and
//          one write address per cycle; a read to the address being written
//          returns the old contents. No reset, so it maps onto block RAM.
// Ports:   clk   - system clock
//          we    - write enable
//          waddr - write column
//          wdata - integral value to store
//          raddr - read column
//          rdata - registered read data (valid the cycle after raddr)
module ii_line_buffer
   import integral_image_builder_pkg::*;
#(
   parameter int DEPTH = II_WIDTH,
   parameter int DW    = II_W,
   parameter int AW    = $clog2(II_WIDTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/integral_image_builder.sv
// rtl/integral_image_builder.sv - raster pixel stream to integral image RAM writer
//
// Purpose: builds ii(r,c) = sum of px(r',c') for r'<=r, c'<=c from a raster stream
//          and writes each value to address r*WIDTH+c, two cycles after the pixel.
// Ports:   clk, rst_n          - clock, asynchronous active-low reset
//          px_valid/px_sof     - pixel qualifier / start of frame (pixel (0,0))
//          px_data             - grayscale pixel
//          wr_en/addr/data     - Integral Image RAM write port
//          frame_done          - pulse with the write of the last word of a frame
//          frame_abort         - pulse when px_sof restarts an unfinished frame
module integral_image_builder
   import integral_image_builder_pkg::*;
#(
   parameter int WIDTH  = II_WIDTH,
   parameter int HEIGHT = II_HEIGHT,
   parameter int ADDR_W = II_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              px_valid,
   input  logic              px_sof,
   input  logic [PX_W-1:0]   px_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [II_W-1:0]   wr_data,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam int SW = PX_W + CW;  // a full row of max pixels fits in SW bits
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   ii_state_t         state_q, state_d;
   logic [CW-1:0]     col_q;
   logic [RW-1:0]     row_q;
   logic [ADDR_W-1:0] addr_q;

   logic              restart, accept, abort_d, pix_last;
   logic [CW-1:0]     pix_col;
   logic [RW-1:0]     pix_row;
   logic [ADDR_W-1:0] pix_addr;

   // S0 stage registers
   logic              s0_valid, s0_row0, s0_last;
   logic [CW-1:0]     s0_col;
   logic [ADDR_W-1:0] s0_addr;
   logic [SW-1:0]     row_sum_q;

   logic [II_W-1:0]   lb_rdata, ii_sum;

   assign restart = px_valid && px_sof;
   assign accept  = restart || (px_valid && (state_q == ST_ACTIVE));
   assign abort_d = restart && (state_q == ST_ACTIVE);

   // A sof pixel is (0,0) of a new frame whatever the counters hold.
   assign pix_col  = restart ? '0 : col_q;
   assign pix_row  = restart ? '0 : row_q;
   assign pix_addr = restart ? '0 : addr_q;
   assign pix_last = (pix_col == COL_LAST) && (pix_row == ROW_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DONE lingers until the last word leaves the pipeline; a new sof may start earlier.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (restart) state_d = ST_ACTIVE;
         ST_ACTIVE: if (accept && pix_last) state_d = ST_DONE;
         ST_DONE: begin
            if (restart) begin
               state_d = ST_ACTIVE;
            end else if (frame_done) begin
               state_d = ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // Position counters and S0: horizontal running sum plus line buffer read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         s0_valid  <= 1'b0;
         s0_row0   <= 1'b0;
         s0_last   <= 1'b0;
         s0_col    <= '0;
         s0_addr   <= '0;
         row_sum_q <= '0;
      end else begin
         s0_valid <= accept;
         if (accept) begin
            col_q     <= (pix_col == COL_LAST) ? '0 : pix_col + 1'b1;
            row_q     <= (pix_col == COL_LAST) ? pix_row + 1'b1 : pix_row;
            addr_q    <= pix_addr + 1'b1;
            s0_row0   <= (pix_row == '0);
            s0_last   <= pix_last;
            s0_col    <= pix_col;
            s0_addr   <= pix_addr;
            row_sum_q <= ((pix_col == '0) ? '0 : row_sum_q) + {{CW{1'b0}}, px_data};
         end
      end
   end

   // S1: add the integral value of the same column one row up.
   assign ii_sum = {{(II_W - SW){1'b0}}, row_sum_q} + (s0_row0 ? '0 : lb_rdata);

   // The S1 write (column c) and the S0 read (column c+1 or 0) never share an
   // address within a frame because WIDTH >= 4.
   ii_line_buffer #(
      .DEPTH (WIDTH),
      .DW    (II_W),
      .AW    (CW)
   ) u_line_buffer (
      .clk   (clk),
      .we    (s0_valid),
      .waddr (s0_col),
      .wdata (ii_sum),
      .raddr (pix_col),
      .rdata (lb_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         wr_en       <= s0_valid;
         frame_done  <= s0_valid && s0_last;
         frame_abort <= abort_d;
         if (s0_valid) begin
            wr_addr <= s0_addr;
            wr_data <= ii_sum;
         end
      end
   end

endmodule

// File: tb/tb_integral_image_builder.sv
// tb/tb_integral_image_builder.sv - scoreboard bench for integral_image_builder
`timescale 1ns/1ps
module tb_integral_image_builder;
   import integral_image_builder_pkg::*;

   localparam int W    = II_WIDTH;
   localparam int H    = II_HEIGHT;
   localparam int NPIX = W * H;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 px_valid = 1'b0;
   logic                 px_sof = 1'b0;
   logic [PX_W-1:0]      px_data = '0;
   logic                 wr_en;
   logic [II_ADDR_W-1:0] wr_addr;
   logic [II_W-1:0]      wr_data;
   logic                 frame_done;
   logic                 frame_abort;

   integral_image_builder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .px_valid    (px_valid),
      .px_sof      (px_sof),
      .px_data     (px_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_done  (frame_done),
      .frame_abort (frame_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      bit done;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   done_data[$];
   exp_t mon_e;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   cyc = 0;
   int   writes_seen = 0;
   int   done_seen = 0;
   int   abort_seen = 0;

   // Reference model: per-column vertical sums accumulated along the row.
   bit   m_active = 0;
   int   m_col = 0;
   int   m_addr = 0;
   int   m_acc = 0;
   int   m_colsum[W];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_abort) abort_seen++;
         if (frame_done) done_seen++;
         if (frame_done && !wr_en) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_without_write cyc=%0d", cyc);
         end
         if (wr_en) begin
            writes_seen++;
            if (frame_done) done_data.push_back(int'(wr_data));
            tests_run++;
            if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d", cyc, wr_addr, wr_data);
            end else begin
               mon_e = sb.pop_front();
               if (wr_addr !== II_ADDR_W'(mon_e.addr) || wr_data !== II_W'(mon_e.data) ||
                   frame_done !== mon_e.done || cyc != mon_e.cyc) begin
                  tests_failed++;
                  $display("FAIL word got addr=%0d data=%0d done=%0b cyc=%0d want addr=%0d data=%0d done=%0b cyc=%0d",
                           wr_addr, wr_data, frame_done, cyc, mon_e.addr, mon_e.data, mon_e.done, mon_e.cyc);
               end
            end
         end
      end
   end

   // Presents one input cycle; accepted pixels queue their expected write.
   task automatic drive(input bit v, input bit s, input int d);
      exp_t e;
      px_valid = v;
      px_sof   = s;
      px_data  = PX_W'(d);
      @(posedge clk);
      #1;
      if (v && (s || m_active)) begin
         if (s) begin
            m_active = 1;
            m_col    = 0;
            m_addr   = 0;
            foreach (m_colsum[i]) m_colsum[i] = 0;
         end
         if (m_col == 0) m_acc = 0;
         m_colsum[m_col] += d;
         m_acc += m_colsum[m_col];
         e.addr = m_addr;
         e.data = m_acc;
         e.done = (m_addr == NPIX - 1);
         e.cyc  = cyc + 1;
         sb.push_back(e);
         m_addr++;
         m_col++;
         if (m_col == W) m_col = 0;
         if (e.done) m_active = 0;
      end
      px_valid = 0;
      px_sof   = 0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({wr_en, frame_done, frame_abort} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags got %b want 000", {wr_en, frame_done, frame_abort});
      end
      tests_run++;
      if (wr_addr !== '0 || wr_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_bus got addr=%0d data=%0d want 0 0", wr_addr, wr_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ignore_before_sof();
      int w0;
      w0 = writes_seen;
      for (int i = 0; i < 20; i++) drive(1, 0, i % 16);
      repeat (4) drive(0, 0, 0);
      tests_run++;
      if (writes_seen != w0) begin
         tests_failed++;
         $display("FAIL ignore_before_sof writes=%0d want 0", writes_seen - w0);
      end
   endtask

   task automatic test_gaps();
      int w0;
      w0 = writes_seen;
      for (int i = 0; i < 30; i++) begin
         drive(1, i == 0, int'($urandom_range(0, 15)));
         repeat (3) drive(0, 0, 0);
      end
      drain("gaps");
      tests_run++;
      if (writes_seen - w0 != 30) begin
         tests_failed++;
         $display("FAIL gaps_count got %0d want 30", writes_seen - w0);
      end
   endtask

   task automatic test_abort_and_reset_mid();
      for (int i = 0; i < 500; i++) drive(1, i == 0, int'($urandom_range(0, 15)));
      drive(1, 1, int'($urandom_range(0, 15)));
      tests_run++;
      if (frame_abort !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_pulse got %b want 1", frame_abort);
      end
      for (int i = 1; i < 8000; i++) drive(1, 0, int'($urandom_range(0, 15)));
      tests_run++;
      if (wr_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_wr_en got %b want 1", wr_en);
      end
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({wr_en, frame_done, frame_abort} !== 3'b000 || wr_addr !== '0 || wr_data !== '0) begin
         tests_failed++;
         $display("FAIL async_reset got en=%b addr=%0d data=%0d want 0 0 0", wr_en, wr_addr, wr_data);
      end
      sb.delete();
      m_active = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ones_frame();
      int d0;
      d0 = done_seen;
      done_data.delete();
      for (int i = 0; i < NPIX; i++) drive(1, i == 0, 1);
      drain("ones");
      tests_run++;
      if (done_seen - d0 != 1 || done_data.size() != 1) begin
         tests_failed++;
         $display("FAIL ones_done_count got %0d want 1", done_seen - d0);
      end else begin
         tests_run++;
         if (done_data[0] != 19200) begin
            tests_failed++;
            $display("FAIL ones_last_word got %0d want 19200", done_data[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int d0, a0;
      d0 = done_seen;
      a0 = abort_seen;
      done_data.delete();
      for (int i = 0; i < NPIX; i++) drive(1, i == 0, 15);
      for (int i = 0; i < NPIX; i++) drive(1, i == 0, (i == 0) ? 7 : 0);
      drain("b2b");
      tests_run++;
      if (abort_seen != a0) begin
         tests_failed++;
         $display("FAIL b2b_abort got %0d want 0", abort_seen - a0);
      end
      tests_run++;
      if (done_seen - d0 != 2 || done_data.size() != 2) begin
         tests_failed++;
         $display("FAIL b2b_done_count got %0d want 2", done_seen - d0);
      end else begin
         tests_run++;
         if (done_data[0] != 288000) begin
            tests_failed++;
            $display("FAIL max_last_word got %0d want 288000", done_data[0]);
         end
         tests_run++;
         if (done_data[1] != 7) begin
            tests_failed++;
            $display("FAIL single_px_last_word got %0d want 7", done_data[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ignore_before_sof();
      test_gaps();
      test_abort_and_reset_mid();
      test_ones_frame();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "timeout");
   end

endmodule
